// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency meter: pin map, byte-select
// encodings and the layout of the status readout byte.
package freq_meter_pkg;

  localparam int unsigned CNT_W    = 24;
  localparam int unsigned SEQ_W    = 5;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned BYTE_W   = 8;

  // ui_in bit positions
  localparam int unsigned UI_SIG     = 0;
  localparam int unsigned UI_ACK     = 1;
  localparam int unsigned UI_RUN     = 2;
  localparam int unsigned UI_HOLD    = 5;
  localparam int unsigned UI_SEL_LSB = 6;

  // uio_out bit positions
  localparam int unsigned UIO_VALID = 0;
  localparam int unsigned UIO_OVF   = 1;
  localparam int unsigned UIO_TICK  = 2;
  localparam logic [7:0]  UIO_OE    = 8'h07;

  // Status byte bit positions (must agree with status_t below)
  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_OVF     = 1;
  localparam int unsigned ST_MISSED  = 2;
  localparam int unsigned ST_SEQ_LSB = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_B0     = 2'b00,
    SEL_B1     = 2'b01,
    SEL_B2     = 2'b10,
    SEL_STATUS = 2'b11
  } sel_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic             missed;
    logic             ovf;
    logic             valid;
  } status_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a previous-sample flop; emits a one-cycle
// pulse on each synchronized rising edge of an asynchronous input.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);
  import freq_meter_pkg::*;

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~prev_q;

endmodule

// File: rtl/tt_um_freq_meter_shivam.sv
// Gated edge-rate meter: counts synchronized rising edges over a fixed window
// and latches each window's count for byte-wise host readout.
module tt_um_freq_meter_shivam #(
  parameter int unsigned GATE_CYCLES = 10000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);
  import freq_meter_pkg::*;

  localparam int unsigned G_W    = $clog2(GATE_CYCLES);
  localparam logic [G_W-1:0] G_LAST = G_W'(GATE_CYCLES - 1);

  logic sig_rise_c;
  logic ack_rise_c;
  logic run;
  logic hold;
  sel_e sel;

  assign run  = ui_in[UI_RUN];
  assign hold = ui_in[UI_HOLD];
  assign sel  = sel_e'(ui_in[UI_SEL_LSB +: SEL_W]);

  logic unused_c;
  assign unused_c = ^{ui_in[4:3], uio_in, ena};

  sync_edge_det u_sig_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ui_in[UI_SIG]),
    .rise_c (sig_rise_c)
  );

  sync_edge_det u_ack_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ui_in[UI_ACK]),
    .rise_c (ack_rise_c)
  );

  logic [G_W-1:0]   g_q, g_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             missed_q, missed_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             tick_q, tick_d;

  logic             close_c;
  logic             cnt_ovf_c;
  logic             win_sat_c;
  logic [CNT_W-1:0] cnt_sum_c;

  // Saturating count including any pulse arriving this cycle
  always_comb begin
    close_c   = run && (g_q == G_LAST);
    cnt_ovf_c = sig_rise_c && (&edge_cnt_q);
    cnt_sum_c = cnt_ovf_c ? edge_cnt_q : edge_cnt_q + CNT_W'(sig_rise_c);
    win_sat_c = sat_q | cnt_ovf_c;
  end

  // Next-state: gate counter, edge counter, result and flags
  always_comb begin
    g_d        = g_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    missed_d   = missed_q;
    seq_d      = seq_q;
    tick_d     = 1'b0;

    if (!run) begin
      g_d        = '0;
      edge_cnt_d = '0;
      sat_d      = 1'b0;
    end else if (close_c) begin
      g_d        = '0;
      edge_cnt_d = '0;
      sat_d      = 1'b0;
      tick_d     = 1'b1;
    end else begin
      g_d        = g_q + G_W'(1);
      edge_cnt_d = cnt_sum_c;
      sat_d      = win_sat_c;
    end

    if (ack_rise_c) begin
      valid_d  = 1'b0;
      missed_d = 1'b0;
    end

    // A close in the same cycle as an ack takes precedence over the clear
    if (close_c) begin
      if (hold) begin
        missed_d = 1'b1;
      end else begin
        result_d = cnt_sum_c;
        ovf_d    = win_sat_c;
        valid_d  = 1'b1;
        seq_d    = seq_q + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q        <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      missed_q   <= 1'b0;
      seq_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      g_q        <= g_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      missed_q   <= missed_d;
      seq_q      <= seq_d;
      tick_q     <= tick_d;
    end
  end

  status_t status_c;
  assign status_c = '{seq: seq_q, missed: missed_q, ovf: ovf_q, valid: valid_q};

  // Readout mux follows the select pins in the same cycle
  always_comb begin
    uo_out = '0;
    case (sel)
      SEL_B0:     uo_out = result_q[7:0];
      SEL_B1:     uo_out = result_q[15:8];
      SEL_B2:     uo_out = result_q[23:16];
      SEL_STATUS: uo_out = status_c;
      default:    uo_out = '0;
    endcase
  end

  always_comb begin
    uio_out            = '0;
    uio_out[UIO_VALID] = valid_q;
    uio_out[UIO_OVF]   = ovf_q;
    uio_out[UIO_TICK]  = tick_q;
  end

  assign uio_oe = UIO_OE;

endmodule

// File: doc/tt_um_freq_meter_shivam.md
# tt_um_freq_meter_shivam

Tiny Tapeout user block that measures the event rate of an external digital signal on `ui_in[0]`. The block counts synchronized rising edges over a fixed gate window and latches each window's count into a result register. The host reads the result byte-wise on `uo_out` and clears the valid flag with an acknowledge pin. It is the consumer end of the counter/pulse-source designs on the same harness: one of those designs drives pins, and this block counts them.

## Interface
- `GATE_CYCLES`, default 10000: gate window length in `clk` cycles; must be ≥ 4.
- `CNT_W`, default 24: result width; fixed at 24 for the byte map below.
- `clk`  in  1  system clock; all logic sits on posedge.
- `rst_n`  in  1  reset: one clock, synchronous, active-low.
- `ui_in`  in  8  [0] signal under test (async); [1] ack (async, rising-edge active); [2] run; [5] hold; [7:6] byte select; others unused.
- `uo_out`  out  8  selected readout byte.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  [0] valid, [1] overflow, [2] gate tick; [7:3] = 0.
- `uio_oe`  out  8  constant 8'h07.
- `ena`  in  1  ignored.

## Operation
- Reset (`rst_n`=0 at posedge): the result, edge count, gate counter, flags, sequence number and sync flops all clear. Output values at reset:
  - `uo_out`=0
  - `uio_out`=0
- Signal path: `ui_in[0]` passes through a 2-FF synchronizer, then a previous-sample flop. The edge pulse is `s2 & ~s_prev`.
- The ack path uses the same structure on `ui_in[1]`.
- Run low:
  - Gate counter and edge count are held at 0.
  - The result and flags are retained.
  - Raising run starts a fresh window at gate count 0.
- Window: gate counter `g` counts 0..GATE_CYCLES-1. On the posedge where `g`=GATE_CYCLES-1 (window close):
  - If hold=0: result ← sat(count + pulse); ovf ← saturated; valid ← 1; seq ← seq+1 (mod 32).
  - If hold=1: the result is unchanged and missed ← 1.
  - In both cases: count ← 0, g ← 0, and the gate tick pulses high for this one cycle.
- Edge count saturates at 2^24−1. The saturation is recorded in ovf at window close, and ovf is overwritten at each close.
- An edge pulse coincident with window close is counted in the closing window.
- Ack rising edge clears valid and missed.
  - If ack and window close occur in the same cycle, the set wins: valid=1 and missed is cleared.
- Readout mux (combinational from registers), selected by `ui_in[7:6]`:
  - 00: result[7:0]
  - 01: result[15:8]
  - 10: result[23:16]
  - 11: status {seq[4:0], missed, ovf, valid}
- Hold exists so the host reads all three bytes coherently.

## Timing
- Pin-to-count latency is 3 clocks. A high level first sampled at posedge k produces the edge pulse during the cycle after posedge k+1, and that pulse is counted at posedge k+2.
- The maximum countable rate is one rising edge per 2 clocks. The input must stay high ≥1 clk and low ≥1 clk.
- Ack latency is 3 clocks, from ack high at posedge k to valid cleared at posedge k+2.
- Window period is exactly GATE_CYCLES clocks while run=1.
- Result, valid and seq update at the window-close posedge.
- `uo_out` follows a `ui_in[7:6]` change in the same cycle, combinationally.
- Reset mid-window discards the partial count. The first window after reset closes GATE_CYCLES clocks after reset deasserts (given run=1).

## Structure
- Package `freq_meter_pkg` holds:
  - CNT_W
  - byte-select encodings (SEL_B0, SEL_B1, SEL_B2, SEL_STATUS)
  - status bit indices (ST_VALID, ST_OVF, ST_MISSED, ST_SEQ_LSB)
  - uio bit indices and the UIO_OE constant
- Sub-module `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse, with synchronous active-low reset. It is instantiated twice, once for the signal and once for ack.
- Top level contains the gate counter, the saturating edge counter, the result/flag registers and the readout mux.

## Test plan
Bench uses GATE_CYCLES=16.
- Reset: hold rst_n=0 for 2 clks with all inputs at 0.
  - Required: `uo_out`=0, `uio_out`=0, `uio_oe`=8'h07.
- Basic count: run=1; toggle `ui_in[0]` with period 4 clk (2 high, 2 low).
  - Required: each window closes with result=4 and valid=1.
  - Required: sel=11 shows the seq incrementing by 1 per window.
  - Required: gate tick pulses every 16 clks.
- Boundary edge: place an edge pulse exactly at the close cycle.
  - Required: that window counts it; the next window starts at 0.
- Ack vs close: ack rising edge alone → valid=0 within 3 clks.
  - Time the ack pulse to coincide with close → valid stays 1.
- Hold: hold=1 across a close.
  - Required: the result is unchanged and missed=1.
  - Release hold, then ack → missed=0.
- Saturation: force the internal edge count to 2^24−2 and apply 3 edges.
  - Required: result=24'hFFFFFF and ovf=1.
  - Required: the next clean window has ovf=0.
  - Separately: reset mid-window → the next result excludes the pre-reset edges.
